// File: rtl/bcd_serial_adder_if.sv
// Start/busy/done handshake and operand/result bus for bcd_serial_adder.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  op_sub;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, a, b, cin, op_sub,
    input  sum, cout, busy, done, err
  );

  modport slave (
    input  start, a, b, cin, op_sub,
    output sum, cout, busy, done, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, one digit per clock LSD first, start/busy/done handshake.
// Define BCD_SUB_EN to add ten's-complement subtract selected by op_sub.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_serial_adder_if.slave  bus
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;
  logic            sub_q, sub_d;

  logic            last_dig;
  logic [3:0]      a_dig, b_dig, b_eff, dig_out;
  logic [4:0]      t;
  logic            dig_gt9;
  logic            err_any;
  logic            busy, done;

`ifndef BCD_SUB_EN
  logic unused_op_sub;
  assign unused_op_sub = bus.op_sub;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      sub_q   <= sub_d;
    end
  end

  assign last_dig = (idx_q == IW'(DIGITS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_dig) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // One digit slice of the ripple; invalid digits go through the same >9 rule.
  always_comb begin
    a_dig   = a_q[{idx_q, 2'b00} +: 4];
    b_dig   = b_q[{idx_q, 2'b00} +: 4];
    b_eff   = sub_q ? (4'd9 - b_dig) : b_dig;
    t       = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
    dig_gt9 = (t > 5'd9);
    dig_out = dig_gt9 ? (t[3:0] + 4'd6) : t[3:0];
  end

  always_comb begin
    err_any = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((bus.a[4*i +: 4] > 4'd9) || (bus.b[4*i +: 4] > 4'd9)) err_any = 1'b1;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    sub_d   = sub_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.b;
          idx_d = '0;
          sum_d = '0;
          err_d = err_any;
`ifdef BCD_SUB_EN
          sub_d   = bus.op_sub;
          carry_d = bus.op_sub ? 1'b1 : bus.cin;
`else
          sub_d   = 1'b0;
          carry_d = bus.cin;
`endif
        end
      end
      S_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = dig_out;
        carry_d = dig_gt9;
        idx_d   = idx_q + 1'b1;
        if (last_dig) cout_d = dig_gt9;
      end
      default: ;
    endcase
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4) using an expected-result queue.
module tb_bcd_serial_adder;
  localparam int DIGITS = 4;
  localparam int MODV   = 10000;
`ifdef BCD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  bcd_serial_adder_if #(.DIGITS(DIGITS)) ifc();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] v;
    int r;
    r = n;
    v = '0;
    for (int i = 0; i < DIGITS; i++) begin
      v[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return v;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    exp_t e;
    int av, bv, r;
    av = bcd2int(a);
    bv = bcd2int(b);
    e.err = 1'b0;
    if (s && SUB_EN) begin
      if (av >= bv) begin r = av - bv; e.cout = 1'b1; end
      else begin r = MODV - (bv - av); e.cout = 1'b0; end
    end else begin
      r = av + bv + int'(c);
      e.cout = (r >= MODV);
      r = r % MODV;
    end
    e.sum = int2bcd(r);
    return e;
  endfunction

  // Drives one request and waits (bounded) for done; lat counts edges after the start edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                       output bit seen, output int lat, output int busy_cnt);
    @(negedge clk);
    ifc.a = a; ifc.b = b; ifc.cin = c; ifc.op_sub = s; ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    seen = 1'b0; lat = 0; busy_cnt = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ifc.done) seen = 1'b1;
      else begin
        if (ifc.busy) busy_cnt++;
        @(posedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0; ifc.op_sub = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ifc.sum !== 16'h0 || ifc.cout !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got sum=%h cout=%b busy=%b done=%b err=%b want all zero",
               ifc.sum, ifc.cout, ifc.busy, ifc.done, ifc.err);
    end
    rst = 1'b0;
  endtask

  task automatic test_add;
    bit seen; int lat, bc; exp_t e;
    sb.push_back(model(16'h1234, 16'h8766, 1'b0, 1'b0));
    issue(16'h1234, 16'h8766, 1'b0, 1'b0, seen, lat, bc);
    e = sb.pop_front();
    checks++;
    if (!seen || ifc.sum !== e.sum || ifc.cout !== e.cout || ifc.err !== e.err) begin
      failures++;
      $display("FAIL add_1234_8766 seen=%b got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
               seen, ifc.sum, ifc.cout, ifc.err, e.sum, e.cout, e.err);
    end
    checks++;
    if (lat !== DIGITS) begin
      failures++;
      $display("FAIL add_latency got %0d edges want %0d", lat, DIGITS);
    end
    checks++;
    if (bc !== DIGITS) begin
      failures++;
      $display("FAIL add_busy_cycles got %0d want %0d", bc, DIGITS);
    end
    @(negedge clk);
    checks++;
    if (ifc.done !== 1'b0 || ifc.busy !== 1'b0 || ifc.sum !== e.sum || ifc.cout !== e.cout) begin
      failures++;
      $display("FAIL done_one_cycle got done=%b busy=%b sum=%h cout=%b want done=0 busy=0 sum=%h cout=%b",
               ifc.done, ifc.busy, ifc.sum, ifc.cout, e.sum, e.cout);
    end

    sb.push_back(model(16'h0999, 16'h0001, 1'b1, 1'b0));
    issue(16'h0999, 16'h0001, 1'b1, 1'b0, seen, lat, bc);
    e = sb.pop_front();
    checks++;
    if (!seen || ifc.sum !== e.sum || ifc.cout !== e.cout || ifc.err !== e.err) begin
      failures++;
      $display("FAIL add_0999_0001_cin seen=%b got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
               seen, ifc.sum, ifc.cout, ifc.err, e.sum, e.cout, e.err);
    end
  endtask

  task automatic test_err;
    bit seen; int lat, bc; exp_t e;
    e.sum = 16'h0100; e.cout = 1'b0; e.err = 1'b1;
    sb.push_back(e);
    issue(16'h00A0, 16'h0000, 1'b0, 1'b0, seen, lat, bc);
    e = sb.pop_front();
    checks++;
    if (!seen || ifc.sum !== e.sum || ifc.cout !== e.cout || ifc.err !== e.err) begin
      failures++;
      $display("FAIL err_invalid_digit seen=%b got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
               seen, ifc.sum, ifc.cout, ifc.err, e.sum, e.cout, e.err);
    end
    sb.push_back(model(16'h0042, 16'h0058, 1'b0, 1'b0));
    issue(16'h0042, 16'h0058, 1'b0, 1'b0, seen, lat, bc);
    e = sb.pop_front();
    checks++;
    if (!seen || ifc.sum !== e.sum || ifc.cout !== e.cout || ifc.err !== e.err) begin
      failures++;
      $display("FAIL err_cleared seen=%b got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
               seen, ifc.sum, ifc.cout, ifc.err, e.sum, e.cout, e.err);
    end
  endtask

  task automatic test_retrigger;
    bit seen; int lat, extra; exp_t e;
    sb.push_back(model(16'h2222, 16'h3333, 1'b0, 1'b0));
    @(negedge clk);
    ifc.a = 16'h2222; ifc.b = 16'h3333; ifc.cin = 1'b0; ifc.op_sub = 1'b0; ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.a = 16'h9999; ifc.b = 16'h9999; ifc.cin = 1'b1;
    seen = 1'b0; lat = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ifc.done) seen = 1'b1;
      else begin
        if (i == 1) ifc.start = 1'b0;
        @(posedge clk);
        lat++;
      end
    end
    e = sb.pop_front();
    checks++;
    if (!seen || lat !== DIGITS || ifc.sum !== e.sum || ifc.cout !== e.cout) begin
      failures++;
      $display("FAIL retrigger_ignored seen=%b lat=%0d got sum=%h cout=%b want lat=%0d sum=%h cout=%b",
               seen, lat, ifc.sum, ifc.cout, DIGITS, e.sum, e.cout);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifc.done || ifc.busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL retrigger_no_queue got %0d busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid_run;
    bit seen; int lat, bc; exp_t e;
    @(negedge clk);
    ifc.a = 16'h4567; ifc.b = 16'h5678; ifc.cin = 1'b1; ifc.op_sub = 1'b0; ifc.start = 1'b1;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ifc.sum !== 16'h0 || ifc.cout !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run got sum=%h cout=%b busy=%b done=%b err=%b want all zero",
               ifc.sum, ifc.cout, ifc.busy, ifc.done, ifc.err);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(model(16'h0005, 16'h0005, 1'b0, 1'b0));
    issue(16'h0005, 16'h0005, 1'b0, 1'b0, seen, lat, bc);
    e = sb.pop_front();
    checks++;
    if (!seen || lat !== DIGITS || ifc.sum !== e.sum || ifc.cout !== e.cout || ifc.err !== e.err) begin
      failures++;
      $display("FAIL after_reset_clean seen=%b lat=%0d got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
               seen, lat, ifc.sum, ifc.cout, ifc.err, e.sum, e.cout, e.err);
    end
  endtask

  task automatic test_op_sub;
    bit seen; int lat, bc; exp_t e;
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vs [3];
    va[0] = 16'h5000; vb[0] = 16'h1234; vs[0] = 1'b1;
    va[1] = 16'h1234; vb[1] = 16'h5000; vs[1] = 1'b1;
    va[2] = 16'h5000; vb[2] = 16'h1234; vs[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(model(va[k], vb[k], 1'b0, vs[k]));
      issue(va[k], vb[k], 1'b0, vs[k], seen, lat, bc);
      e = sb.pop_front();
      checks++;
      if (!seen || ifc.sum !== e.sum || ifc.cout !== e.cout || ifc.err !== e.err) begin
        failures++;
        $display("FAIL op_sub_case%0d sub=%b seen=%b got sum=%h cout=%b want sum=%h cout=%b",
                 k, vs[k], seen, ifc.sum, ifc.cout, e.sum, e.cout);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit seen; int lat, bc; exp_t e;
    logic [15:0] ra, rb; logic rc, rs;
    for (int k = 0; k < 10; k++) begin
      ra = int2bcd(int'($urandom_range(0, 9999)));
      rb = int2bcd(int'($urandom_range(0, 9999)));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      sb.push_back(model(ra, rb, rc, rs));
      issue(ra, rb, rc, rs, seen, lat, bc);
      e = sb.pop_front();
      checks++;
      if (!seen || lat !== DIGITS || ifc.sum !== e.sum || ifc.cout !== e.cout || ifc.err !== e.err) begin
        failures++;
        $display("FAIL random_op%0d a=%h b=%h cin=%b sub=%b lat=%0d got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
                 k, ra, rb, rc, rs, lat, ifc.sum, ifc.cout, ifc.err, e.sum, e.cout, e.err);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add();
    test_err();
    test_retrigger();
    test_reset_mid_run();
    test_op_sub();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "timeout");
  end
endmodule
